// File: rtl/bomb_keypad_entry.sv
// rtl/bomb_keypad_entry.sv - 4x4 keypad scanner, debouncer and defuse-code entry checker
module bomb_keypad_entry #(
   parameter int          SCAN_DIV        = 30,
   parameter int          DEBOUNCE_FRAMES = 3,
   parameter int          CODE_LEN        = 4,
   parameter logic [15:0] CODE            = 16'h1234,
   parameter int          MAX_TRIES       = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic [3:0] row,
   input  logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic [2:0] digits,
   output logic       success,
   output logic       wrong,
   output logic       lockout
);

   localparam int                DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int                STAB_W     = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(SCAN_DIV - 1);
   localparam logic [STAB_W-1:0] STAB_MAX   = STAB_W'(DEBOUNCE_FRAMES);
   localparam logic [2:0]        CODE_LEN_V = 3'(CODE_LEN);
   localparam logic [2:0]        TRIES_V    = 3'(MAX_TRIES);
   localparam logic [15:0]       CODE_MASK  = 16'((33'd1 << (4 * CODE_LEN)) - 33'd1);
   localparam logic [4:0]        RES_NONE   = 5'h10;
   localparam logic [3:0]        KEY_STAR   = 4'd14;

   typedef enum logic {
      DB_RELEASED,
      DB_PRESSED
   } db_state_t;

   typedef enum logic [1:0] {
      EN_IDLE,
      EN_ARMED,
      EN_DONE_OK,
      EN_LOCKED
   } en_state_t;

   // keypad position to key code; '*' and '#' get the two top codes
   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      case ({r, c})
         4'h0: k = 4'd1;
         4'h1: k = 4'd2;
         4'h2: k = 4'd3;
         4'h3: k = 4'd10;
         4'h4: k = 4'd4;
         4'h5: k = 4'd5;
         4'h6: k = 4'd6;
         4'h7: k = 4'd11;
         4'h8: k = 4'd7;
         4'h9: k = 4'd8;
         4'hA: k = 4'd9;
         4'hB: k = 4'd12;
         4'hC: k = 4'd14;
         4'hD: k = 4'd0;
         4'hE: k = 4'd15;
         default: k = 4'd13;
      endcase
      return k;
   endfunction

   logic [3:0]        col_meta;
   logic [3:0]        col_sync;
   logic              scan_en;
   logic [DIV_W-1:0]  div_cnt;
   logic [1:0]        row_idx;
   logic              div_tc;
   logic              frame_end;

   logic [3:0]        col_low;
   logic [2:0]        row_hits;
   logic [1:0]        col_idx;
   logic [1:0]        row_sat;
   logic [2:0]        hit_sum;
   logic [1:0]        tot_hits;
   logic [3:0]        row_key;
   logic [3:0]        frame_key;
   logic [4:0]        frame_res;
   logic [1:0]        acc_hits;
   logic [3:0]        acc_key;

   db_state_t         db_state;
   db_state_t         db_next;
   logic [4:0]        last_res;
   logic [STAB_W-1:0] stab_cnt;
   logic [STAB_W-1:0] stab_next;
   logic              accept;

   en_state_t         en_state;
   en_state_t         en_next;
   logic [15:0]       code_buf;
   logic [15:0]       buf_n;
   logic [2:0]        digits_n;
   logic [2:0]        tries;
   logic [2:0]        tries_n;
   logic              success_n;
   logic              wrong_n;
   logic              lockout_n;

   // two-flop synchronizer for the asynchronous column inputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_meta <= 4'hF;
         col_sync <= 4'hF;
      end else begin
         col_meta <= col;
         col_sync <= col_meta;
      end
   end

   assign div_tc    = scan_en && (div_cnt == DIV_LAST);
   assign frame_end = div_tc && (row_idx == 2'd3);
   assign row       = scan_en ? ~(4'b0001 << row_idx) : 4'b1111;

   // row-step divider; scanning begins the cycle after start is seen
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_en <= 1'b0;
         div_cnt <= '0;
         row_idx <= 2'd0;
      end else if (!start) begin
         scan_en <= 1'b0;
         div_cnt <= '0;
         row_idx <= 2'd0;
      end else begin
         scan_en <= 1'b1;
         if (scan_en) begin
            if (div_tc) begin
               div_cnt <= '0;
               row_idx <= row_idx + 2'd1;
            end else begin
               div_cnt <= div_cnt + DIV_W'(1);
            end
         end
      end
   end

   // decode the current row sample and merge it with the frame so far
   always_comb begin
      col_low  = ~col_sync;
      row_hits = 3'(col_low[0]) + 3'(col_low[1]) + 3'(col_low[2]) + 3'(col_low[3]);
      col_idx  = 2'd0;
      for (int c = 0; c < 4; c++) begin
         if (col_low[c]) col_idx = 2'(c);
      end
      row_sat   = (row_hits >= 3'd2) ? 2'd2 : row_hits[1:0];
      hit_sum   = {1'b0, acc_hits} + {1'b0, row_sat};
      tot_hits  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
      row_key   = key_map(row_idx, col_idx);
      frame_key = (row_hits == 3'd1) ? row_key : acc_key;
      frame_res = (tot_hits == 2'd1) ? {1'b0, frame_key} : RES_NONE;
   end

   // per-frame accumulation of how many keys were seen and which one
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_hits <= 2'd0;
         acc_key  <= 4'd0;
      end else if (!start) begin
         acc_hits <= 2'd0;
         acc_key  <= 4'd0;
      end else if (div_tc) begin
         if (frame_end) begin
            acc_hits <= 2'd0;
            acc_key  <= 4'd0;
         end else begin
            acc_hits <= tot_hits;
            if (row_hits == 3'd1) acc_key <= row_key;
         end
      end
   end

   // debounce next state: a press or release needs a run of identical frames
   always_comb begin
      db_next   = db_state;
      accept    = 1'b0;
      stab_next = stab_cnt;
      if (frame_res == last_res) begin
         if (stab_cnt != STAB_MAX) stab_next = stab_cnt + STAB_W'(1);
      end else begin
         stab_next = STAB_W'(1);
      end
      if (frame_end) begin
         case (db_state)
            DB_RELEASED: begin
               if (!frame_res[4] && (stab_next == STAB_MAX)) begin
                  db_next = DB_PRESSED;
                  accept  = 1'b1;
               end
            end
            default: begin
               if (frame_res[4] && (stab_next == STAB_MAX)) db_next = DB_RELEASED;
            end
         endcase
      end
   end

   // debounce state, stability run and the accepted key outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         db_state  <= DB_RELEASED;
         last_res  <= RES_NONE;
         stab_cnt  <= '0;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
      end else if (!start) begin
         db_state  <= DB_RELEASED;
         last_res  <= RES_NONE;
         stab_cnt  <= '0;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
      end else begin
         db_state  <= db_next;
         key_valid <= accept;
         if (accept) key_code <= frame_res[3:0];
         if (frame_end) begin
            last_res <= frame_res;
            stab_cnt <= stab_next;
         end
      end
   end

   // entry next state: collect digits, compare one cycle after the buffer fills
   always_comb begin
      en_next   = en_state;
      buf_n     = code_buf;
      digits_n  = digits;
      tries_n   = tries;
      success_n = success;
      wrong_n   = 1'b0;
      lockout_n = lockout;
      case (en_state)
         EN_IDLE: en_next = EN_ARMED;
         EN_ARMED: begin
            if (digits == CODE_LEN_V) begin
               if ((code_buf & CODE_MASK) == (CODE & CODE_MASK)) begin
                  success_n = 1'b1;
                  en_next   = EN_DONE_OK;
               end else begin
                  wrong_n  = 1'b1;
                  buf_n    = 16'h0000;
                  digits_n = 3'd0;
                  tries_n  = tries + 3'd1;
                  if ((tries + 3'd1) == TRIES_V) begin
                     lockout_n = 1'b1;
                     en_next   = EN_LOCKED;
                  end
               end
            end else if (key_valid) begin
               if (key_code <= 4'd9) begin
                  buf_n    = {code_buf[11:0], key_code};
                  digits_n = digits + 3'd1;
               end else if (key_code == KEY_STAR) begin
                  buf_n    = 16'h0000;
                  digits_n = 3'd0;
               end
            end
         end
         default: en_next = en_state;
      endcase
   end

   // entry state and result registers, cleared whenever start is low
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en_state <= EN_IDLE;
         code_buf <= 16'h0000;
         digits   <= 3'd0;
         tries    <= 3'd0;
         success  <= 1'b0;
         wrong    <= 1'b0;
         lockout  <= 1'b0;
      end else if (!start) begin
         en_state <= EN_IDLE;
         code_buf <= 16'h0000;
         digits   <= 3'd0;
         tries    <= 3'd0;
         success  <= 1'b0;
         wrong    <= 1'b0;
         lockout  <= 1'b0;
      end else begin
         en_state <= en_next;
         code_buf <= buf_n;
         digits   <= digits_n;
         tries    <= tries_n;
         success  <= success_n;
         wrong    <= wrong_n;
         lockout  <= lockout_n;
      end
   end

endmodule

// File: tb/tb_bomb_keypad_entry.sv
// tb/tb_bomb_keypad_entry.sv - directed scoreboard bench for bomb_keypad_entry
module tb_bomb_keypad_entry;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_valid;
   logic [2:0] digits;
   logic       success;
   logic       wrong;
   logic       lockout;
   logic [15:0] key_down = 16'h0000;

   always #5 clk = ~clk;

   // matrix model: a held key pulls its column low while its row is driven low
   always_comb begin
      col = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (key_down[r*4+c] && !row[r]) col[c] = 1'b0;
   end

   bomb_keypad_entry #(
      .SCAN_DIV(4), .DEBOUNCE_FRAMES(2), .CODE_LEN(4), .CODE(16'h1234), .MAX_TRIES(3)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .row(row), .col(col),
      .key_code(key_code), .key_valid(key_valid), .digits(digits),
      .success(success), .wrong(wrong), .lockout(lockout)
   );

   // output monitor
   int         cyc = 0;
   int         n_obs = 0;
   int         kv_cyc = 0;
   int         succ_cyc = 0;
   int         n_succ = 0;
   int         n_wrong = 0;
   int         wrong_cyc = 0;
   logic       prev_succ = 1'b0;
   logic [3:0] obs_code [256];

   always @(negedge clk) begin
      cyc <= cyc + 1;
      prev_succ <= success;
      if (key_valid === 1'b1) begin
         if (n_obs < 256) obs_code[n_obs] <= key_code;
         n_obs  <= n_obs + 1;
         kv_cyc <= cyc;
      end
      if (success === 1'b1 && prev_succ !== 1'b1) begin
         succ_cyc <= cyc;
         n_succ   <= n_succ + 1;
      end
      if (wrong === 1'b1) begin
         n_wrong   <= n_wrong + 1;
         wrong_cyc <= cyc;
      end
   end

   int         checks = 0;
   int         failures = 0;
   int         n_exp = 0;
   int         rd = 0;
   logic [3:0] exp_q [$];
   logic [3:0] kmap [16] = '{4'd1, 4'd2, 4'd3, 4'd10, 4'd4, 4'd5, 4'd6, 4'd11,
                             4'd7, 4'd8, 4'd9, 4'd12, 4'd14, 4'd0, 4'd15, 4'd13};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      logic [3:0] e;
      while (exp_q.size() > 0 && rd < n_obs) begin
         e = exp_q.pop_front();
         chk("key_code", 32'(obs_code[rd]), 32'(e));
         rd++;
      end
      chk("kv_count", n_obs, n_exp);
   endtask

   task automatic press(input int r, input int c, input bit valid);
      key_down = 16'h0000;
      key_down[r*4+c] = 1'b1;
      step(80);
      key_down = 16'h0000;
      step(80);
      if (valid) begin
         exp_q.push_back(kmap[r*4+c]);
         n_exp++;
      end
      drain();
   endtask

   task automatic press_digit(input int d);
      if (d == 0) press(3, 1, 1'b1);
      else press((d - 1) / 3, (d - 1) % 3, 1'b1);
   endtask

   task automatic rearm();
      start = 1'b0;
      step(2);
      start = 1'b1;
      step(2);
      rd = n_obs;
      n_exp = n_obs;
      exp_q.delete();
   endtask

   initial begin
      int k;
      int base_wrong;
      int base_succ;
      logic [3:0] exp_row;
      rst = 1'b0;
      start = 1'b0;
      step(3);
      chk("rst_row", 32'(row), 32'hF);
      chk("rst_key_code", 32'(key_code), 0);
      chk("rst_key_valid", 32'(key_valid), 0);
      chk("rst_digits", 32'(digits), 0);
      chk("rst_success", 32'(success), 0);
      chk("rst_wrong", 32'(wrong), 0);
      chk("rst_lockout", 32'(lockout), 0);
      rst = 1'b1;
      step(100);
      chk("idle_row", 32'(row), 32'hF);
      chk("idle_outputs", {key_code, key_valid, digits, success, wrong, lockout}, 0);

      // scan sequence
      start = 1'b1;
      k = 0;
      while (row !== 4'b1110 && k < 5) begin
         step(1);
         k++;
      end
      for (int i = 0; i < 20; i++) begin
         exp_row = ~(4'b0001 << ((i / 4) % 4));
         chk("scan_row", 32'(row), 32'(exp_row));
         step(1);
      end

      // single press and glitch
      press(2, 1, 1'b1);
      chk("single_code", 32'(key_code), 8);
      chk("single_digits", 32'(digits), 1);
      key_down = 16'h0000;
      key_down[2*4+1] = 1'b1;
      step(16);
      key_down = 16'h0000;
      step(80);
      drain();
      chk("glitch_digits", 32'(digits), 1);

      // correct code
      rearm();
      for (int d = 1; d <= 4; d++) begin
         press_digit(d);
         chk("ok_digits", 32'(digits), 32'(d));
      end
      chk("ok_success", 32'(success), 1);
      chk("ok_latency", succ_cyc - kv_cyc, 2);
      base_wrong = n_wrong;
      press_digit(5);
      chk("done_digits", 32'(digits), 4);
      chk("done_wrong", n_wrong, base_wrong);
      chk("done_success", 32'(success), 1);

      // wrong code and lockout
      rearm();
      base_wrong = n_wrong;
      base_succ  = n_succ;
      for (int t = 0; t < 3; t++) begin
         press_digit(1);
         press_digit(2);
         press_digit(3);
         press_digit(5);
         chk("wrong_count", n_wrong - base_wrong, t + 1);
         chk("wrong_latency", wrong_cyc - kv_cyc, 2);
         chk("wrong_digits", 32'(digits), 0);
         chk("wrong_lockout", 32'(lockout), (t == 2) ? 1 : 0);
      end
      chk("lock_success", 32'(success), 0);
      chk("lock_no_succ", n_succ, base_succ);

      // clear and ignored keys
      rearm();
      press_digit(1);
      press_digit(2);
      chk("clr_two", 32'(digits), 2);
      press(3, 0, 1'b1);
      chk("clr_star", 32'(digits), 0);
      press(0, 3, 1'b1);
      chk("clr_a", 32'(digits), 0);
      press(3, 2, 1'b1);
      chk("clr_hash", 32'(digits), 0);
      for (int d = 1; d <= 4; d++) press_digit(d);
      chk("clr_success", 32'(success), 1);
      rearm();
      key_down = 16'h0003;
      step(80);
      key_down = 16'h0000;
      step(80);
      drain();
      chk("double_digits", 32'(digits), 0);

      // abort and re-arm, then asynchronous reset
      press_digit(1);
      press_digit(2);
      press_digit(3);
      chk("abort_digits", 32'(digits), 3);
      start = 1'b0;
      step(1);
      chk("abort_outputs", {key_code, key_valid, digits, success, wrong, lockout}, 0);
      chk("abort_row", 32'(row), 32'hF);
      rearm();
      for (int d = 1; d <= 4; d++) press_digit(d);
      chk("rearm_success", 32'(success), 1);
      step(7);
      rst = 1'b0;
      #1;
      chk("async_row", 32'(row), 32'hF);
      chk("async_success", 32'(success), 0);
      step(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
